neuron_mac: RTL and testbench
=============================

// Module: neuron_mac
// PURPOSE
//  Float32 dot-product stage of one neuron: sum = b + sum_i(x[i]*w[i]) over N lanes.
//  Sits directly upstream of the activation stage; its sum/done feed that stage's x/start.
//  One mul_float and one add_float instance, time-shared across lanes, driven by a start/done FSM.
// PARAMETERS
//  S  32  float width in bits; only 32 (IEEE-754 single) is supported
//  N  4   number of input lanes; lane i = bits [S*i +: S]; N >= 1
// PORTS
//  clk    in   1    clock; all state updates on posedge
//  rst_n  in   1    synchronous, active-low reset
//  start  in   1    1-cycle request; sampled only in IDLE
//  x      in   S*N  input activations, packed lanes
//  w      in   S*N  weights, packed lanes
//  b      in   S    bias
//  sum    out  S    result; held stable from done until the next accepted start
//  done   out  1    1-cycle pulse when sum is valid
//  busy   out  1    high from the cycle after an accepted start until done
//  err    out  1    sticky: any mul/add reported NaN or overflow in the current run
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, sum=0, done=0, busy=0, err=0, lane counter=0.
//  Reset mid-run aborts; the float units' resets are also held low; no done is produced.
//  IDLE: on start, latch x, w, b into registers; acc<=b (see CONFIGURATION); i<=0; err<=0; ->MUL_GO.
//   Inputs may change freely after the accepting cycle.
//  MUL_GO: mul start=1 for exactly one cycle, operands xr[i], wr[i]; ->MUL_WAIT.
//  MUL_WAIT: wait for mul done; on done capture product p, OR nan|overflow into err; ->ADD_GO.
//  ADD_GO: add start=1 for one cycle, operands acc, p (op=add); ->ADD_WAIT.
//  ADD_WAIT: on add done acc<=result, OR flags into err;
//   if i==N-1 ->FINISH else i<=i+1, ->MUL_GO.
//  FINISH: sum<=acc, done=1 this cycle only, busy=0; ->IDLE.
//  Latency start->done = 1 + N*(2 + Lm + La) + 1 cycles, Lm/La = unit done latencies.
//  start while busy: ignored (no restart, no queuing). start and done same cycle: impossible
//   (done only in FINISH); start in the cycle after FINISH is accepted normally.
//  Underflow/zero flags from the units are ignored; denormals treated as the units treat them.
//  Unit done levels sampled only in the matching WAIT state; stale done from a previous op ignored.
//  Lane counter width $clog2(N) (min 1); no wrap beyond N-1.
// CONFIGURATION
//  NEURON_MAC_BIAS_EN defined: acc initialised to latched b.
//  NEURON_MAC_BIAS_EN undefined: acc initialised to +0.0 (32'h00000000); b port kept but ignored.
// STRUCTURE
//  Shared package neuron_pkg: FP_ZERO=32'h00000000, FP_ONE=32'h3f800000, FP_HALF=32'h3f000000,
//   FSM state encoding (IDLE, MUL_GO, MUL_WAIT, ADD_GO, ADD_WAIT, FINISH).
//  No new sub-module: the lane select is a single indexed part-select; reuse existing
//   mul_float and add_float, one instance each.
// TESTING
//  N=4, x={1,2,3,4}, w=all 0.5, b=1.0, BIAS_EN -> done once, sum=32'h40c00000 (6.0), err=0.
//  Same stimulus, BIAS_EN undefined -> sum=32'h40a00000 (5.0).
//  x={-1,-1,-1,-1}(bf800000), w=all 1.0, b=4.0 -> sum=32'h00000000 (+0.0); busy high throughout.
//  Pulse start again while busy and change x -> ignored; first run result unchanged, one done.
//  rst_n=0 for 1 cycle mid-run (in MUL_WAIT of lane 2) -> no done; sum=0; a new start completes correctly.
//  x[0]=32'h7fc00000 (NaN) -> done with err=1; next clean run -> err=0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants and FSM state encoding for the neuron dot-product datapath.
package neuron_pkg;

  localparam logic [31:0] FP_ZERO = 32'h00000000;
  localparam logic [31:0] FP_ONE  = 32'h3f800000;
  localparam logic [31:0] FP_HALF = 32'h3f000000;

  typedef enum logic [2:0] {
    IDLE,
    MUL_GO,
    MUL_WAIT,
    ADD_GO,
    ADD_WAIT,
    FINISH
  } state_t;

endpackage

// File: rtl/add_float.sv
// IEEE-754 single adder/subtractor (op=1 subtracts), one registered stage.
// Denormal inputs are flushed to zero; bits shifted out during alignment are truncated.
module add_float (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        nan,
  output logic        overflow,
  output logic        underflow,
  output logic        zero
);

  logic        sa, sb, sl, ss, a_ge, found;
  logic [7:0]  ea, eb, el, es, d;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [26:0] ma, mb, ml, ms, mal, diff, norm;
  logic [27:0] sum28;
  logic [8:0]  e9;
  logic [4:0]  sh;
  logic [31:0] r_c;
  logic        nan_c, ovf_c, unf_c, zero_c;
  logic        unused_lsbs;

  assign unused_lsbs = ^{sum28[2:0], norm[26], norm[2:0]};

  always_comb begin
    sa    = a[31];
    sb    = b[31] ^ op;
    ea    = a[30:23];
    eb    = b[30:23];
    a_nan = (ea == 8'hff) && (a[22:0] != 23'd0);
    b_nan = (eb == 8'hff) && (b[22:0] != 23'd0);
    a_inf = (ea == 8'hff) && (a[22:0] == 23'd0);
    b_inf = (eb == 8'hff) && (b[22:0] == 23'd0);
    ma    = (ea != 8'd0) ? {1'b1, a[22:0], 3'b000} : 27'd0;
    mb    = (eb != 8'd0) ? {1'b1, b[22:0], 3'b000} : 27'd0;
    a_ge  = (a[30:0] >= b[30:0]);
    sl    = a_ge ? sa : sb;
    ss    = a_ge ? sb : sa;
    el    = a_ge ? ea : eb;
    es    = a_ge ? eb : ea;
    ml    = a_ge ? ma : mb;
    ms    = a_ge ? mb : ma;
    d     = el - es;
    mal   = (d > 8'd26) ? 27'd0 : (ms >> d);
    sum28 = {1'b0, ml} + {1'b0, mal};
    diff  = ml - mal;
    sh    = 5'd0;
    found = 1'b0;
    for (int k = 26; k >= 0; k--) begin
      if (!found && diff[k]) begin
        sh    = 5'(26 - k);
        found = 1'b1;
      end
    end
    norm   = diff << sh;
    e9     = {1'b0, el} + {8'd0, sum28[27]};
    r_c    = 32'd0;
    nan_c  = 1'b0;
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
    zero_c = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      r_c   = 32'h7fc00000;
      nan_c = 1'b1;
    end else if (a_inf) begin
      r_c = {sa, 8'hff, 23'd0};
    end else if (b_inf) begin
      r_c = {sb, 8'hff, 23'd0};
    end else if (ml == 27'd0) begin
      r_c    = {sl & ss, 31'd0};
      zero_c = 1'b1;
    end else if (sl == ss) begin
      if (e9 >= 9'd255) begin
        r_c   = {sl, 8'hff, 23'd0};
        ovf_c = 1'b1;
      end else begin
        r_c = {sl, e9[7:0], sum28[27] ? sum28[26:4] : sum28[25:3]};
      end
    end else if (diff == 27'd0) begin
      zero_c = 1'b1;
    end else if ({3'b000, sh} >= el) begin
      r_c    = {sl, 31'd0};
      unf_c  = 1'b1;
      zero_c = 1'b1;
    end else begin
      r_c = {sl, el - {3'b000, sh}, norm[25:3]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= 32'd0;
      done      <= 1'b0;
      nan       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        result    <= r_c;
        nan       <= nan_c;
        overflow  <= ovf_c;
        underflow <= unf_c;
        zero      <= zero_c;
      end
    end
  end

endmodule

// File: rtl/mul_float.sv
// IEEE-754 single multiplier, one registered stage: done pulses the cycle after start.
// Denormal inputs are flushed to zero and the product mantissa is truncated.
module mul_float (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        nan,
  output logic        overflow,
  output logic        underflow,
  output logic        zero
);

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0] prod;
  logic [9:0]  esum;
  logic [22:0] frac;
  logic [31:0] r_c;
  logic        nan_c, ovf_c, unf_c, zero_c;
  logic        unused_prod_lsbs;

  assign unused_prod_lsbs = ^prod[22:0];

  always_comb begin
    ea     = a[30:23];
    eb     = b[30:23];
    fa     = a[22:0];
    fb     = b[22:0];
    sign   = a[31] ^ b[31];
    a_nan  = (ea == 8'hff) && (fa != 23'd0);
    b_nan  = (eb == 8'hff) && (fb != 23'd0);
    a_inf  = (ea == 8'hff) && (fa == 23'd0);
    b_inf  = (eb == 8'hff) && (fb == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    prod   = 48'({1'b1, fa}) * 48'({1'b1, fb});
    // Biased exponent sum still carries one extra bias; 382 = 127 + 255.
    esum   = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]};
    frac   = prod[47] ? prod[46:24] : prod[45:23];
    r_c    = {sign, 31'd0};
    nan_c  = 1'b0;
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
    zero_c = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r_c   = 32'h7fc00000;
      nan_c = 1'b1;
    end else if (a_inf || b_inf) begin
      r_c = {sign, 8'hff, 23'd0};
    end else if (a_zero || b_zero) begin
      zero_c = 1'b1;
    end else if (esum >= 10'd382) begin
      r_c   = {sign, 8'hff, 23'd0};
      ovf_c = 1'b1;
    end else if (esum <= 10'd127) begin
      unf_c  = 1'b1;
      zero_c = 1'b1;
    end else begin
      r_c = {sign, 8'(esum - 10'd127), frac};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= 32'd0;
      done      <= 1'b0;
      nan       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        result    <= r_c;
        nan       <= nan_c;
        overflow  <= ovf_c;
        underflow <= unf_c;
        zero      <= zero_c;
      end
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Float32 neuron dot product sum = b + sum(x[i]*w[i]) using one shared multiplier and adder.
// Define NEURON_MAC_BIAS_EN to seed the accumulator with b; otherwise it starts at +0.0.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int S = 32,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [S*N-1:0] x,
  input  logic [S*N-1:0] w,
  input  logic [S-1:0] b,
  output logic [S-1:0] sum,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [LW-1:0] LAST = LW'(N - 1);

  state_t          state, state_nxt;
  logic [S*N-1:0]  xr, wr;
  logic [S-1:0]    acc, prod, acc_init;
  logic [LW-1:0]   lane;
  logic            last_lane;
  logic            mul_start, add_start;
  logic [S-1:0]    mul_res, add_res;
  logic            mul_done, mul_nan, mul_ovf;
  logic            add_done, add_nan, add_ovf;
  logic            mul_unused_uf, mul_unused_zero, add_unused_uf, add_unused_zero;

`ifdef NEURON_MAC_BIAS_EN
  assign acc_init = b;
`else
  logic unused_bias;
  assign acc_init    = FP_ZERO;
  assign unused_bias = ^b;
`endif

  assign last_lane = (lane == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    add_start = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = MUL_GO;
      end
      MUL_GO: begin
        mul_start = 1'b1;
        state_nxt = MUL_WAIT;
      end
      MUL_WAIT: if (mul_done) state_nxt = ADD_GO;
      ADD_GO: begin
        add_start = 1'b1;
        state_nxt = ADD_WAIT;
      end
      ADD_WAIT: if (add_done) state_nxt = last_lane ? FINISH : MUL_GO;
      FINISH: begin
        done      = 1'b1;
        busy      = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // sum is written on the last add so it is already valid in the done cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xr   <= '0;
      wr   <= '0;
      acc  <= FP_ZERO;
      prod <= FP_ZERO;
      lane <= '0;
      sum  <= FP_ZERO;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          xr   <= x;
          wr   <= w;
          acc  <= acc_init;
          lane <= '0;
          err  <= 1'b0;
        end
        MUL_WAIT: if (mul_done) begin
          prod <= mul_res;
          err  <= err | mul_nan | mul_ovf;
        end
        ADD_WAIT: if (add_done) begin
          acc <= add_res;
          err <= err | add_nan | add_ovf;
          if (last_lane) sum  <= add_res;
          else           lane <= lane + 1'b1;
        end
        default: ;
      endcase
    end
  end

  mul_float u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start),
    .a         (xr[S*lane +: S]),
    .b         (wr[S*lane +: S]),
    .result    (mul_res),
    .done      (mul_done),
    .nan       (mul_nan),
    .overflow  (mul_ovf),
    .underflow (mul_unused_uf),
    .zero      (mul_unused_zero)
  );

  add_float u_add (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (add_start),
    .op        (1'b0),
    .a         (acc),
    .b         (prod),
    .result    (add_res),
    .done      (add_done),
    .nan       (add_nan),
    .overflow  (add_ovf),
    .underflow (add_unused_uf),
    .zero      (add_unused_zero)
  );

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac; expected sums follow NEURON_MAC_BIAS_EN.
`timescale 1ns/1ps
module tb_neuron_mac;
  import neuron_pkg::*;

  localparam int S = 32;
  localparam int N = 4;

`ifdef NEURON_MAC_BIAS_EN
  localparam logic [31:0] EXP_DOT    = 32'h40c00000;
  localparam logic [31:0] EXP_CANCEL = 32'h00000000;
`else
  localparam logic [31:0] EXP_DOT    = 32'h40a00000;
  localparam logic [31:0] EXP_CANCEL = 32'hc0800000;
`endif

  localparam logic [S*N-1:0] X_DOT  = {32'h40800000, 32'h40400000, 32'h40000000, FP_ONE};
  localparam logic [S*N-1:0] X_NEG  = {N{32'hbf800000}};
  localparam logic [S*N-1:0] X_NAN  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h7fc00000};
  localparam logic [S*N-1:0] W_HALF = {N{FP_HALF}};
  localparam logic [S*N-1:0] W_ONE  = {N{FP_ONE}};

  logic           clk = 1'b0;
  logic           rst_n, start;
  logic [S*N-1:0] x, w;
  logic [S-1:0]   b, sum;
  logic           done, busy, err;
  int             vectors = 0;
  int             miscompares = 0;

  always #5 clk = ~clk;

  neuron_mac #(.S(S), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .w     (w),
    .b     (b),
    .sum   (sum),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  // Starts a run and watches it at negedges; restart_at/reset_at inject events at cycle k.
  task automatic run_mac(input logic [S*N-1:0] xv, input logic [S*N-1:0] wv,
                         input logic [S-1:0] bv, input int restart_at, input int reset_at,
                         input int tail, output int ndone, output logic [S-1:0] s,
                         output logic e, output logic busy_ok);
    int k;
    int left;
    x = xv;
    w = wv;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    s = '0;
    e = 1'b0;
    busy_ok = 1'b1;
    k = 1;
    left = -1;
    while (k <= 120 && left != 0) begin
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          s = sum;
          e = err;
          left = tail + 1;
        end
      end else if (ndone == 0 && reset_at < 0 && busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      if (left > 0) left--;
      if (k == restart_at) begin
        x = {N{32'h40800000}};
        start = 1'b1;
      end else if (k == restart_at + 1) begin
        start = 1'b0;
      end
      if (k == reset_at) rst_n = 1'b0;
      else if (k == reset_at + 1) rst_n = 1'b1;
      if (left != 0) @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    w = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (sum !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_sum: got %h expected %h", sum, 32'h0); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_dot();
    int nd; logic [S-1:0] s; logic e, bok;
    run_mac(X_DOT, W_HALF, FP_ONE, -1, -1, 4, nd, s, e, bok);
    vectors++; if (nd !== 1) begin miscompares++; $display("[TB] FAIL dot_done_count: got %0d expected 1", nd); end
    vectors++; if (s !== EXP_DOT) begin miscompares++; $display("[TB] FAIL dot_sum: got %h expected %h", s, EXP_DOT); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL dot_err: got %b expected 0", e); end
    vectors++; if (bok !== 1'b1) begin miscompares++; $display("[TB] FAIL dot_busy: got %b expected 1", bok); end
  endtask

  task automatic test_cancel();
    int nd; logic [S-1:0] s; logic e, bok;
    run_mac(X_NEG, W_ONE, 32'h40800000, -1, -1, 2, nd, s, e, bok);
    vectors++; if (nd !== 1) begin miscompares++; $display("[TB] FAIL cancel_done_count: got %0d expected 1", nd); end
    vectors++; if (s !== EXP_CANCEL) begin miscompares++; $display("[TB] FAIL cancel_sum: got %h expected %h", s, EXP_CANCEL); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_err: got %b expected 0", e); end
    vectors++; if (bok !== 1'b1) begin miscompares++; $display("[TB] FAIL cancel_busy: got %b expected 1", bok); end
  endtask

  task automatic test_busy_ignore();
    int nd; logic [S-1:0] s; logic e, bok;
    run_mac(X_DOT, W_HALF, FP_ONE, 5, -1, 6, nd, s, e, bok);
    vectors++; if (nd !== 1) begin miscompares++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", nd); end
    vectors++; if (s !== EXP_DOT) begin miscompares++; $display("[TB] FAIL ignore_sum: got %h expected %h", s, EXP_DOT); end
    vectors++; if (sum !== EXP_DOT) begin miscompares++; $display("[TB] FAIL ignore_sum_held: got %h expected %h", sum, EXP_DOT); end
    vectors++; if (bok !== 1'b1) begin miscompares++; $display("[TB] FAIL ignore_busy: got %b expected 1", bok); end
  endtask

  task automatic test_reset_midrun();
    int nd; logic [S-1:0] s; logic e, bok;
    run_mac(X_DOT, W_HALF, FP_ONE, -1, 10, 0, nd, s, e, bok);
    vectors++; if (nd !== 0) begin miscompares++; $display("[TB] FAIL abort_done_count: got %0d expected 0", nd); end
    vectors++; if (sum !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_sum: got %h expected %h", sum, 32'h0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    run_mac(X_DOT, W_HALF, FP_ONE, -1, -1, 2, nd, s, e, bok);
    vectors++; if (nd !== 1) begin miscompares++; $display("[TB] FAIL after_abort_done_count: got %0d expected 1", nd); end
    vectors++; if (s !== EXP_DOT) begin miscompares++; $display("[TB] FAIL after_abort_sum: got %h expected %h", s, EXP_DOT); end
  endtask

  task automatic test_nan();
    int nd; logic [S-1:0] s; logic e, bok;
    run_mac(X_NAN, W_HALF, FP_ONE, -1, -1, 2, nd, s, e, bok);
    vectors++; if (nd !== 1) begin miscompares++; $display("[TB] FAIL nan_done_count: got %0d expected 1", nd); end
    vectors++; if (e !== 1'b1) begin miscompares++; $display("[TB] FAIL nan_err: got %b expected 1", e); end
    run_mac(X_DOT, W_HALF, FP_ONE, -1, -1, 2, nd, s, e, bok);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL clean_err: got %b expected 0", e); end
    vectors++; if (s !== EXP_DOT) begin miscompares++; $display("[TB] FAIL clean_sum: got %h expected %h", s, EXP_DOT); end
  endtask

  task automatic test_back_to_back();
    int nd; logic [S-1:0] s; logic e, bok;
    run_mac(X_DOT, W_HALF, FP_ONE, -1, -1, 0, nd, s, e, bok);
    vectors++; if (s !== EXP_DOT) begin miscompares++; $display("[TB] FAIL b2b_first_sum: got %h expected %h", s, EXP_DOT); end
    @(negedge clk);
    run_mac(X_NEG, W_ONE, 32'h40800000, -1, -1, 2, nd, s, e, bok);
    vectors++; if (nd !== 1) begin miscompares++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", nd); end
    vectors++; if (s !== EXP_CANCEL) begin miscompares++; $display("[TB] FAIL b2b_second_sum: got %h expected %h", s, EXP_CANCEL); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_dot();
    test_cancel();
    test_busy_ignore();
    test_reset_midrun();
    test_nan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
